// File: rtl/seq_scale_multiplier.sv
// Iterative shift-add multiplier: scales an unsigned sample by a runtime factor,
// one multiplier bit per cycle, with the product saturated to OUT_WIDTH.
module seq_scale_multiplier #(
    parameter int IN_WIDTH  = 32,
    parameter int MUL_WIDTH = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic [MUL_WIDTH-1:0] mul,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 sat
);

    localparam int ACC_WIDTH = IN_WIDTH + MUL_WIDTH;
    localparam int CNT_WIDTH = (MUL_WIDTH > 1) ? $clog2(MUL_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(MUL_WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state;
    logic [ACC_WIDTH-1:0] mcand;
    logic [ACC_WIDTH-1:0] acc;
    logic [MUL_WIDTH-1:0] mreg;
    logic [CNT_WIDTH-1:0] cnt;

    logic [ACC_WIDTH-1:0] acc_next;
    logic [ACC_WIDTH-1:0] acc_high;
    logic                 sat_next;
    logic [OUT_WIDTH-1:0] dout_next;

    // acc_high collapses to zero when OUT_WIDTH == ACC_WIDTH, so sat ties off.
    always_comb begin
        acc_next  = mreg[0] ? acc + mcand : acc;
        acc_high  = acc_next >> OUT_WIDTH;
        sat_next  = |acc_high;
        dout_next = sat_next ? {OUT_WIDTH{1'b1}} : acc_next[OUT_WIDTH-1:0];
    end

    assign din_ready  = (state == IDLE);
    assign dout_valid = (state == DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            mcand <= '0;
            acc   <= '0;
            mreg  <= '0;
            cnt   <= '0;
            dout  <= '0;
            sat   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every step reads the pre-edge acc/mcand/mreg.
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        mcand <= ACC_WIDTH'(din);
                        mreg  <= mul;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mreg  <= mreg >> 1;
                    cnt   <= cnt + CNT_WIDTH'(1);
                    // Fixed latency: the last step publishes the result including its own add.
                    if (cnt == LAST_STEP) begin
                        dout  <= dout_next;
                        sat   <= sat_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (dout_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scale_multiplier.sv
// Bench for seq_scale_multiplier: transaction-level model of the handshake and
// saturated product, checked every cycle, plus literal pins per directed vector.
module tb_seq_scale_multiplier;

    localparam int IW = 32;
    localparam int MW = 8;
    localparam int OW = 32;
    localparam int AW = IW + MW;

    logic          clk        = 1'b0;
    logic          resetn     = 1'b0;
    logic          din_valid  = 1'b0;
    logic          din_ready;
    logic [IW-1:0] din        = '0;
    logic [MW-1:0] mul        = '0;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [OW-1:0] dout;
    logic          sat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_scale_multiplier #(
        .IN_WIDTH (IW),
        .MUL_WIDTH(MW),
        .OUT_WIDTH(OW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din       (din),
        .mul       (mul),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout      (dout),
        .sat       (sat)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one op in flight; result due MW edges after acceptance,
    // presented until an edge sees dout_ready; no acceptance on the retiring edge.
    bit            m_busy = 1'b0;
    longint        m_cyc  = 0;
    longint        m_due  = 0;
    logic [OW-1:0] m_dout = '0;
    logic          m_sat  = 1'b0;

    always @(posedge clk or negedge resetn) begin
        logic          showing;
        logic [AW-1:0] full;
        logic [AW-1:0] max_out;
        if (!resetn) begin
            m_busy = 1'b0;
        end else begin
            showing = m_busy && (m_cyc >= m_due);
            m_cyc   = m_cyc + 1;
            if (showing && dout_ready) begin
                m_busy = 1'b0;
            end else if (!m_busy && din_valid) begin
                full    = AW'(din) * AW'(mul);
                max_out = AW'({OW{1'b1}});
                m_sat   = (full > max_out);
                m_dout  = m_sat ? {OW{1'b1}} : full[OW-1:0];
                m_due   = m_cyc + MW;
                m_busy  = 1'b1;
            end
        end
    end

    // Hand-computed literals for the current directed vector.
    logic [OW-1:0] pin_dout = '0;
    logic          pin_sat  = 1'b0;
    int            pin_seq  = 0;
    int            pin_done = 0;
    bit            prev_valid = 1'b0;

    always begin
        bit exp_valid;
        @(negedge clk or negedge resetn);
        #1;
        if (!resetn) begin
            check("reset_dout_valid", 64'(dout_valid), 64'(0));
            check("reset_din_ready",  64'(din_ready),  64'(1));
            check("reset_dout",       64'(dout),       64'(0));
            check("reset_sat",        64'(sat),        64'(0));
            prev_valid = 1'b0;
        end else begin
            exp_valid = m_busy && (m_cyc >= m_due);
            check("dout_valid", 64'(dout_valid), 64'(exp_valid));
            check("din_ready",  64'(din_ready),  64'(!m_busy));
            if (exp_valid) begin
                check("dout", 64'(dout), 64'(m_dout));
                check("sat",  64'(sat),  64'(m_sat));
                if (!prev_valid && (pin_seq != pin_done)) begin
                    pin_done = pin_seq;
                    check("pin_model_dout", 64'(m_dout), 64'(pin_dout));
                    check("pin_model_sat",  64'(m_sat),  64'(pin_sat));
                    check("pin_dut_dout",   64'(dout),   64'(pin_dout));
                    check("pin_dut_sat",    64'(sat),    64'(pin_sat));
                end
            end
            prev_valid = exp_valid;
        end
    end

    // Accept a pair, scramble the inputs while busy, then retire after 'stall'
    // cycles of backpressure (0 = dout_ready already high when the result lands).
    task automatic run_op(input logic [IW-1:0] a, input logic [MW-1:0] b,
                          input logic [OW-1:0] exp_dout, input logic exp_sat,
                          input int stall);
        @(negedge clk);
        pin_dout   = exp_dout;
        pin_sat    = exp_sat;
        pin_seq    = pin_seq + 1;
        din        = a;
        mul        = b;
        din_valid  = 1'b1;
        dout_ready = (stall == 0);
        @(negedge clk);
        din_valid  = 1'b0;
        din        = ~a;
        mul        = ~b;
        repeat (MW) @(negedge clk);
        if (stall > 0) begin
            din_valid = 1'b1;
            din       = 32'h1234_5678;
            mul       = 8'h05;
            @(negedge clk);
            din_valid = 1'b0;
            repeat (stall - 1) @(negedge clk);
            dout_ready = 1'b1;
        end
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        run_op(32'h0000_000B, 8'h04, 32'h0000_002C, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 8'hFF, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'h3FFF_FFFF, 8'h04, 32'hFFFF_FFFC, 1'b0, 0);
        run_op(32'h4000_0000, 8'h04, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'h0000_CAFE, 8'h00, 32'h0000_0000, 1'b0, 0);
        run_op(32'h0000_0000, 8'hFF, 32'h0000_0000, 1'b0, 0);
        run_op(32'h0000_BEAD, 8'h10, 32'h000B_EAD0, 1'b0, 5);
        run_op(32'h0100_0000, 8'hFF, 32'hFF00_0000, 1'b0, 2);
        run_op(32'h0000_0003, 8'h81, 32'h0000_0183, 1'b0, 0);

        // Abandon an operation mid-flight with an asynchronous reset pulse.
        @(negedge clk);
        din        = 32'h00FA_CADE;
        mul        = 8'h03;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #10 resetn = 1'b1;
        repeat (12) @(negedge clk);
        dout_ready = 1'b0;

        run_op(32'h0000_0ACE, 8'h02, 32'h0000_159C, 1'b0, 0);

        repeat (3) @(negedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_scale_multiplier.md
Name: seq_scale_multiplier

Overview:
Iterative shift-add multiplier that scales an unsigned sample up by a runtime unsigned factor. It is the expansion-side counterpart of the rounding divider.
- Result is saturated to OUT_WIDTH; a flag reports when saturation occurred.
- valid/ready handshake on input and output; one operation in flight at a time.

Parameters:
IN_WIDTH, 32, width of unsigned multiplicand din
MUL_WIDTH, 8, width of unsigned multiplier mul; also the iteration count
OUT_WIDTH, 32, width of dout; constraint OUT_WIDTH <= IN_WIDTH+MUL_WIDTH

Ports:
clk  input  1  single clock, rising edge
resetn  input  1  asynchronous, active-low reset
din_valid  input  1  din/mul valid
din_ready  output  1  block can accept an operand pair
din  input  IN_WIDTH  unsigned multiplicand
mul  input  MUL_WIDTH  unsigned multiplier
dout_valid  output  1  result valid
dout_ready  input  1  downstream accepts result
dout  output  OUT_WIDTH  saturated product
sat  output  1  1 = product exceeded 2^OUT_WIDTH-1 and dout was clamped

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-low (resetn).
- Reset values: state=IDLE, din_ready=1, dout_valid=0, dout=0, sat=0, accumulator=0, counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - din_ready=1.
  - On an edge with din_valid=1:
    - load mcand = zero-extended din (IN_WIDTH+MUL_WIDTH bits);
    - load mreg = mul, acc = 0, cnt = 0;
    - go to BUSY.
  - din/mul are sampled only at this edge and ignored afterwards.
- BUSY:
  - din_ready=0. Each edge performs one step:
    - if mreg[0]=1 then acc += mcand;
    - mcand <<= 1; mreg >>= 1; cnt++.
  - The step at cnt==MUL_WIDTH-1 is the last one. At that edge:
    - go to DONE;
    - register dout and sat from the final acc (including that step's add).
- Latency and throughput:
  - dout_valid rises exactly MUL_WIDTH cycles after the accept edge.
  - Latency is fixed; there is no early termination when mul runs out of ones.
- Arithmetic:
  - acc is IN_WIDTH+MUL_WIDTH bits and can never overflow.
  - If acc[IN_WIDTH+MUL_WIDTH-1:OUT_WIDTH] != 0, then dout = all ones and sat=1.
  - Otherwise dout = acc[OUT_WIDTH-1:0] and sat=0.
  - When OUT_WIDTH == IN_WIDTH+MUL_WIDTH, sat is constant 0.
- DONE:
  - dout_valid=1; dout and sat are held stable while dout_ready=0, for an unbounded time.
  - On an edge with dout_ready=1: dout_valid drops, go to IDLE.
  - dout and sat retain their last value; they are don't-care while dout_valid=0.
- Input handshake rules:
  - din_ready=0 in DONE, so no new operand is accepted on the same edge as output retirement.
  - Throughput is one result per MUL_WIDTH+2 cycles minimum.
- Boundary operands:
  - mul=0 or din=0: full MUL_WIDTH-cycle latency still applies; dout=0, sat=0.
- Reset mid-operation: asserting resetn=0 in BUSY or DONE abandons the operation immediately (asynchronous). All outputs take their reset values and no stale result is ever presented.
- Illegal/ignored stimulus:
  - din_valid in BUSY/DONE is ignored.
  - dout_ready in IDLE/BUSY is ignored.

Test Plan:
- Basic multiply: din=0xB, mul=0x04, dout_ready=1 -> dout=0x2C, sat=0. dout_valid asserted exactly 8 cycles after the accept edge, for 1 cycle.
- Saturate at max operands: din=0xFFFF_FFFF, mul=0xFF -> full product 0xFE_FFFF_FF01 -> dout=0xFFFF_FFFF, sat=1.
- Boundary just below and at overflow:
  - din=0x3FFF_FFFF, mul=4 -> dout=0xFFFF_FFFC, sat=0.
  - din=0x4000_0000, mul=4 -> dout=0xFFFF_FFFF, sat=1.
- Zero operands:
  - din=0xCAFE, mul=0 -> dout=0, sat=0, latency still 8 cycles.
  - din=0, mul=0xFF -> dout=0, sat=0.
- Backpressure: din=0xBEAD, mul=0x10 (-> 0xBEAD0), dout_ready low for 5 cycles after dout_valid rises:
  - dout and sat remain stable; din_ready=0 throughout; a din_valid pulse during DONE is not accepted.
  - Retires on the dout_ready=1 edge; din_ready=1 on the next cycle.
- Reset mid-operation:
  - Accept din=0xFACADE, mul=0x3; drop resetn for 1 cycle during BUSY -> outputs return to reset values immediately.
  - After release: no dout_valid occurs. A new din=0xACE, mul=2 gives dout=0x159C, sat=0.
